// File: rtl/execute_pkg.sv
// Shared types and helpers for the execute stage.
// Build option DIVIDE_EN enables the DIVU/REMU multi-cycle operations.
package execute_pkg;

    typedef logic [31:0] regval_t;
    typedef logic [4:0]  reg_idx_t;

    // DIVU/REMU codes stay reserved even when the divider is not built.
    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpXor  = 4'd4,
        OpShl  = 4'd5,
        OpShr  = 4'd6,
        OpMul  = 4'd7,
        OpDivu = 4'd8,
        OpRemu = 4'd9
    } operation_t;

    typedef enum logic [1:0] {
        AdjNone = 2'd0,
        AdjAdd  = 2'd1,
        AdjShl  = 2'd2
    } adjustment_operation_t;

    function automatic logic is_multicycle(operation_t op);
        case (op)
            OpMul: return 1'b1;
`ifdef DIVIDE_EN
            OpDivu, OpRemu: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/execute_if.sv
// Pipeline links into and out of the execute stage.
// Each link carries a backward hold that stalls the producing side.
interface i_read_to_execute;
    import execute_pkg::*;

    logic                  is_valid;
    regval_t               pc;
    reg_idx_t              destination;
    logic                  destination_is_memory;
    regval_t               left_value;
    regval_t               right_value;
    operation_t            operation;
    regval_t               adjustment;
    adjustment_operation_t adjustment_operation;
    logic                  has_flushed;
    logic                  hold;

    modport execute_in (
        input  is_valid, pc, destination, destination_is_memory, left_value, right_value,
               operation, adjustment, adjustment_operation, has_flushed,
        output hold
    );

    modport read_out (
        output is_valid, pc, destination, destination_is_memory, left_value, right_value,
               operation, adjustment, adjustment_operation, has_flushed,
        input  hold
    );
endinterface

interface i_execute_to_write;
    import execute_pkg::*;

    logic     is_valid;
    regval_t  pc;
    reg_idx_t destination;
    logic     destination_is_memory;
    regval_t  result;
    logic     has_flushed;
    logic     hold;

    modport execute_out (
        output is_valid, pc, destination, destination_is_memory, result, has_flushed,
        input  hold
    );

    modport write_in (
        input  is_valid, pc, destination, destination_is_memory, result, has_flushed,
        output hold
    );
endinterface

// File: rtl/execute_iterative_muldiv.sv
// 32-step shift-add multiplier, plus a restoring divider when DIVIDE_EN is defined.
// The result is held in DONE until ack_i is seen.
module iterative_muldiv
    import execute_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       start_i,
    input  operation_t op_i,
    input  regval_t    a_i,
    input  regval_t    b_i,
    input  logic       ack_i,
    output logic       busy_o,
    output logic       done_o,
    output regval_t    result_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t     state_q;
    logic [4:0] count_q;
    operation_t op_q;
    // MUL: acc = product, a = multiplicand, b = multiplier.
    // DIV: acc = remainder, a = dividend shifting into quotient, b = divisor.
    regval_t    acc_q;
    regval_t    a_q;
    regval_t    b_q;

`ifdef DIVIDE_EN
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    assign rem_shift = {acc_q, a_q[31]};
    assign rem_diff  = rem_shift - {1'b0, b_q};
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            count_q <= '0;
            op_q    <= OpMul;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_q <= StBusy;
                        count_q <= '0;
                        op_q    <= op_i;
                        acc_q   <= '0;
                        a_q     <= a_i;
                        b_q     <= b_i;
                    end
                end
                StBusy: begin
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        state_q <= StDone;
                    end
                    if (op_q == OpMul) begin
                        if (b_q[0]) begin
                            acc_q <= acc_q + a_q;
                        end
                        a_q <= a_q << 1;
                        b_q <= b_q >> 1;
                    end
`ifdef DIVIDE_EN
                    else begin
                        // Borrow out of the 33-bit trial means the divisor did not fit.
                        a_q   <= {a_q[30:0], ~rem_diff[32]};
                        acc_q <= rem_diff[32] ? rem_shift[31:0] : rem_diff[31:0];
                    end
`endif
                end
                StDone: begin
                    if (ack_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = (state_q == StBusy);
    assign done_o = (state_q == StDone);

    always_comb begin
        result_o = acc_q;
`ifdef DIVIDE_EN
        if (op_q == OpDivu) begin
            result_o = a_q;
        end
`endif
    end

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU plus an iterative engine for MUL (and DIVU/REMU
// when DIVIDE_EN is defined), with a registered output toward write-back.
module execute
    import execute_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_n,
    i_read_to_execute.execute_in          ini,
    i_execute_to_write.execute_out        outi
);

    regval_t  eff_right;
    regval_t  alu_result;
    regval_t  eng_result;
    logic     is_mc;
    logic     eng_start;
    logic     eng_ack;
    logic     eng_busy;
    logic     eng_done;

    logic     valid_q, valid_d;
    logic     flushed_q, flushed_d;
    logic     dmem_q, dmem_d;
    regval_t  pc_q, pc_d;
    regval_t  result_q, result_d;
    reg_idx_t dest_q, dest_d;

    always_comb begin
        case (ini.adjustment_operation)
            AdjAdd:  eff_right = ini.right_value + ini.adjustment;
            AdjShl:  eff_right = ini.right_value << ini.adjustment[4:0];
            default: eff_right = ini.right_value;
        endcase
    end

    always_comb begin
        case (ini.operation)
            OpAdd:   alu_result = ini.left_value + eff_right;
            OpSub:   alu_result = ini.left_value - eff_right;
            OpAnd:   alu_result = ini.left_value & eff_right;
            OpOr:    alu_result = ini.left_value | eff_right;
            OpXor:   alu_result = ini.left_value ^ eff_right;
            OpShl:   alu_result = ini.left_value << eff_right[4:0];
            OpShr:   alu_result = ini.left_value >> eff_right[4:0];
            default: alu_result = '0;
        endcase
    end

    assign is_mc     = is_multicycle(ini.operation);
    assign eng_start = ini.is_valid && is_mc && !eng_busy && !eng_done;
    assign eng_ack   = eng_done && !outi.hold;
    assign ini.hold  = reset_n && (outi.hold || (ini.is_valid && is_mc && !eng_done));

    iterative_muldiv u_muldiv (
        .clock    (clock),
        .reset_n  (reset_n),
        .start_i  (eng_start),
        .op_i     (ini.operation),
        .a_i      (ini.left_value),
        .b_i      (eff_right),
        .ack_i    (eng_ack),
        .busy_o   (eng_busy),
        .done_o   (eng_done),
        .result_o (eng_result)
    );

    always_comb begin
        valid_d   = valid_q;
        flushed_d = flushed_q;
        dmem_d    = dmem_q;
        pc_d      = pc_q;
        dest_d    = dest_q;
        result_d  = result_q;
        if (!outi.hold) begin
            if (!ini.is_valid) begin
                valid_d   = 1'b0;
                flushed_d = ini.has_flushed;
            end else if (is_mc && !eng_done) begin
                // Bubble while the engine iterates; the instruction stays upstream.
                valid_d   = 1'b0;
                flushed_d = 1'b0;
            end else begin
                valid_d   = 1'b1;
                flushed_d = ini.has_flushed;
                dmem_d    = ini.destination_is_memory;
                pc_d      = ini.pc;
                dest_d    = ini.destination;
                result_d  = is_mc ? eng_result : alu_result;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q   <= 1'b0;
            flushed_q <= 1'b0;
            dmem_q    <= 1'b0;
            pc_q      <= '0;
            dest_q    <= '0;
            result_q  <= '0;
        end else begin
            valid_q   <= valid_d;
            flushed_q <= flushed_d;
            dmem_q    <= dmem_d;
            pc_q      <= pc_d;
            dest_q    <= dest_d;
            result_q  <= result_d;
        end
    end

    assign outi.is_valid              = valid_q;
    assign outi.has_flushed           = flushed_q;
    assign outi.destination_is_memory = dmem_q;
    assign outi.pc                    = pc_q;
    assign outi.destination           = dest_q;
    assign outi.result                = result_q;

endmodule

// File: tb/tb_execute.sv
// Scoreboard bench for the execute stage; define DIVIDE_EN to cover DIVU/REMU.
module tb_execute;
    import execute_pkg::*;

    typedef struct {
        regval_t  result;
        regval_t  pc;
        reg_idx_t dest;
        logic     dmem;
        logic     flushed;
    } exp_t;

    typedef struct packed {
        operation_t            op;
        regval_t               l;
        regval_t               r;
        regval_t               adj;
        adjustment_operation_t aop;
    } vec_t;

    logic clock;
    logic reset_n;
    int   checks = 0;
    int   passes = 0;
    exp_t sb[$];

    i_read_to_execute  rte ();
    i_execute_to_write etw ();

    execute dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ini     (rte),
        .outi    (etw)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic regval_t model(operation_t op, regval_t l, regval_t r, regval_t adj,
                                      adjustment_operation_t aop);
        regval_t     e;
        logic [63:0] p;
        if (aop == AdjAdd) e = r + adj;
        else if (aop == AdjShl) e = r << adj[4:0];
        else e = r;
        p = {32'd0, l} * {32'd0, e};
        case (op)
            OpAdd: return l + e;
            OpSub: return l - e;
            OpAnd: return l & e;
            OpOr:  return l | e;
            OpXor: return l ^ e;
            OpShl: return l << e[4:0];
            OpShr: return l >> e[4:0];
            OpMul: return p[31:0];
`ifdef DIVIDE_EN
            OpDivu: return (e == 32'd0) ? 32'hFFFF_FFFF : l / e;
            OpRemu: return (e == 32'd0) ? l : l % e;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input operation_t op, input regval_t l, input regval_t r,
                         input regval_t adj, input adjustment_operation_t aop, input regval_t pc);
        exp_t e;
        rte.is_valid              = 1'b1;
        rte.operation             = op;
        rte.left_value            = l;
        rte.right_value           = r;
        rte.adjustment            = adj;
        rte.adjustment_operation  = aop;
        rte.pc                    = pc;
        rte.destination           = pc[6:2];
        rte.destination_is_memory = pc[3];
        rte.has_flushed           = pc[4];
        e.result  = model(op, l, r, adj, aop);
        e.pc      = pc;
        e.dest    = pc[6:2];
        e.dmem    = pc[3];
        e.flushed = pc[4];
        sb.push_back(e);
    endtask

    task automatic idle(input logic hf);
        rte.is_valid    = 1'b0;
        rte.has_flushed = hf;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        etw.hold = 1'b1;
        drive(OpMul, 32'd3, 32'd4, 32'd0, AdjNone, 32'h10);
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({etw.is_valid, etw.has_flushed, rte.hold} !== 3'b000)
            $display("FAIL reset_state: valid/flushed/hold=%b%b%b expected 000",
                     etw.is_valid, etw.has_flushed, rte.hold);
        else passes++;
        @(negedge clock);
        etw.hold = 1'b0;
        idle(1'b0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if (etw.is_valid !== 1'b0)
            $display("FAIL reset_release_valid: got %b expected 0", etw.is_valid);
        else passes++;
    endtask

    // Consecutive single-cycle ops, one per cycle, each checked one edge later.
    task automatic test_single_cycle();
        vec_t v[9];
        exp_t e;
        v[0] = '{OpAdd, 32'd5, 32'd7, 32'd3, AdjAdd};
        v[1] = '{OpSub, 32'd0, 32'd1, 32'd0, AdjNone};
        v[2] = '{OpAnd, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, AdjNone};
        v[3] = '{OpOr,  32'h1234_0000, 32'h0000_5678, 32'd0, AdjNone};
        v[4] = '{OpXor, 32'hFFFF_FFFF, 32'h1234_5678, 32'd0, AdjNone};
        v[5] = '{OpShl, 32'd1, 32'd3, 32'd2, AdjShl};
        v[6] = '{OpShr, 32'h8000_0000, 32'd33, 32'd0, AdjNone};
        v[7] = '{OpAdd, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, AdjAdd};
        v[8] = '{OpShl, 32'd3, 32'h20, 32'd0, AdjNone};
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            drive(v[i].op, v[i].l, v[i].r, v[i].adj, v[i].aop, 32'h100 + 32'(i) * 4);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            checks++;
            if ({etw.is_valid, etw.result, etw.pc, etw.destination, etw.destination_is_memory,
                 etw.has_flushed} !== {1'b1, e.result, e.pc, e.dest, e.dmem, e.flushed})
                $display("FAIL single_%0d: valid=%b res=%h pc=%h expected valid=1 res=%h pc=%h",
                         i, etw.is_valid, etw.result, etw.pc, e.result, e.pc);
            else passes++;
        end
        checks++;
        if (etw.result !== 32'h0000_0003)
            $display("FAIL shl_mask: got %h expected 00000003", etw.result);
        else passes++;
        @(negedge clock);
        idle(1'b0);
        @(posedge clock);
        #1;
        checks++;
        if (etw.is_valid !== 1'b0)
            $display("FAIL single_bubble: got valid=%b expected 0", etw.is_valid);
        else passes++;
    endtask

    task automatic test_undefined();
        exp_t e;
        @(negedge clock);
        drive(operation_t'(4'hF), 32'd3, 32'd4, 32'd0, AdjNone, 32'h200);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        if ({etw.is_valid, etw.result, etw.pc} !== {1'b1, 32'd0, e.pc})
            $display("FAIL undefined_op: valid=%b res=%h pc=%h expected valid=1 res=0 pc=%h",
                     etw.is_valid, etw.result, etw.pc, e.pc);
        else passes++;
`ifndef DIVIDE_EN
        @(negedge clock);
        drive(OpDivu, 32'd100, 32'd7, 32'd0, AdjNone, 32'h204);
        #1;
        checks++;
        if (rte.hold !== 1'b0)
            $display("FAIL divu_disabled_hold: got %b expected 0", rte.hold);
        else passes++;
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        if ({etw.is_valid, etw.result, etw.pc} !== {1'b1, e.result, e.pc})
            $display("FAIL divu_disabled: valid=%b res=%h expected valid=1 res=%h",
                     etw.is_valid, etw.result, e.result);
        else passes++;
`endif
        @(negedge clock);
        idle(1'b0);
    endtask

    task automatic test_mul();
        exp_t e;
        int   cnt;
        @(negedge clock);
        drive(OpMul, 32'hFFFF_FFFF, 32'd2, 32'd0, AdjNone, 32'h300);
        cnt = 0;
        #1;
        while (rte.hold && cnt < 40) begin
            cnt++;
            @(negedge clock);
            #1;
        end
        checks++;
        if (cnt !== 33) $display("FAIL mul_hold_cycles: got %0d expected 33", cnt);
        else passes++;
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        if ({etw.is_valid, etw.result, etw.pc, etw.destination, etw.has_flushed} !==
            {1'b1, e.result, e.pc, e.dest, e.flushed})
            $display("FAIL mul_result: valid=%b res=%h pc=%h expected valid=1 res=%h pc=%h",
                     etw.is_valid, etw.result, etw.pc, e.result, e.pc);
        else passes++;
        @(negedge clock);
        idle(1'b0);
        #1;
        checks++;
        if (rte.hold !== 1'b0) $display("FAIL mul_hold_release: got %b expected 0", rte.hold);
        else passes++;
    endtask

    task automatic test_done_hold();
        exp_t e;
        int   cnt;
        logic [32:0] snap;
        @(negedge clock);
        drive(OpMul, 32'h0001_2345, 32'h0000_6789, 32'd0, AdjNone, 32'h400);
        cnt = 0;
        #1;
        while (rte.hold && cnt < 40) begin
            cnt++;
            @(negedge clock);
            #1;
        end
        etw.hold = 1'b1;
        snap = {etw.is_valid, etw.result};
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            checks++;
            if ({etw.is_valid, etw.result} !== snap || rte.hold !== 1'b1)
                $display("FAIL done_hold_%0d: valid/res=%h hold=%b expected %h hold=1",
                         i, {etw.is_valid, etw.result}, rte.hold, snap);
            else passes++;
        end
        @(negedge clock);
        etw.hold = 1'b0;
        #1;
        checks++;
        if (rte.hold !== 1'b0) $display("FAIL done_persist: hold=%b expected 0", rte.hold);
        else passes++;
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        if ({etw.is_valid, etw.result, etw.pc} !== {1'b1, e.result, e.pc})
            $display("FAIL done_release: valid=%b res=%h expected valid=1 res=%h",
                     etw.is_valid, etw.result, e.result);
        else passes++;
        @(negedge clock);
        idle(1'b0);
    endtask

    // Downstream stalls across a whole MUL: output keeps the ADD, engine keeps iterating.
    task automatic test_hold_busy();
        exp_t e;
        exp_t first;
        @(negedge clock);
        drive(OpAdd, 32'd10, 32'd20, 32'd0, AdjNone, 32'h500);
        @(posedge clock);
        #1;
        first = sb.pop_front();
        @(negedge clock);
        etw.hold = 1'b1;
        drive(OpMul, 32'd1000, 32'd3000, 32'd0, AdjNone, 32'h504);
        repeat (40) @(posedge clock);
        #1;
        checks++;
        if ({etw.is_valid, etw.result, etw.pc} !== {1'b1, first.result, first.pc})
            $display("FAIL busy_hold_keep: valid=%b res=%h pc=%h expected valid=1 res=%h pc=%h",
                     etw.is_valid, etw.result, etw.pc, first.result, first.pc);
        else passes++;
        @(negedge clock);
        etw.hold = 1'b0;
        #1;
        checks++;
        if (rte.hold !== 1'b0) $display("FAIL busy_hold_done: hold=%b expected 0", rte.hold);
        else passes++;
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        if ({etw.is_valid, etw.result, etw.pc} !== {1'b1, e.result, e.pc})
            $display("FAIL busy_hold_result: valid=%b res=%h expected valid=1 res=%h",
                     etw.is_valid, etw.result, e.result);
        else passes++;
        @(negedge clock);
        idle(1'b0);
    endtask

    task automatic test_reset_mid_busy();
        exp_t e;
        @(negedge clock);
        drive(OpMul, 32'd77, 32'd99, 32'd0, AdjNone, 32'h600);
        repeat (11) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({etw.is_valid, rte.hold} !== 2'b00)
            $display("FAIL midbusy_reset: valid=%b hold=%b expected 0 0", etw.is_valid, rte.hold);
        else passes++;
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        drive(OpAdd, 32'd40, 32'd2, 32'd0, AdjNone, 32'h604);
        #1;
        checks++;
        if (rte.hold !== 1'b0) $display("FAIL midbusy_add_hold: hold=%b expected 0", rte.hold);
        else passes++;
        @(posedge clock);
        #1;
        e = sb.pop_front();
        checks++;
        if ({etw.is_valid, etw.result, etw.pc} !== {1'b1, e.result, e.pc})
            $display("FAIL midbusy_add: valid=%b res=%h expected valid=1 res=%h",
                     etw.is_valid, etw.result, e.result);
        else passes++;
        @(negedge clock);
        idle(1'b0);
    endtask

`ifdef DIVIDE_EN
    task automatic test_div();
        vec_t v[5];
        exp_t e;
        int   cnt;
        v[0] = '{OpDivu, 32'd100, 32'd7, 32'd0, AdjNone};
        v[1] = '{OpRemu, 32'd100, 32'd7, 32'd0, AdjNone};
        v[2] = '{OpDivu, 32'd9, 32'd0, 32'd0, AdjNone};
        v[3] = '{OpRemu, 32'd9, 32'd0, 32'd0, AdjNone};
        v[4] = '{OpDivu, 32'hFFFF_FFFF, 32'd3, 32'd2, AdjShl};
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            drive(v[i].op, v[i].l, v[i].r, v[i].adj, v[i].aop, 32'h700 + 32'(i) * 4);
            cnt = 0;
            do begin
                @(posedge clock);
                #1;
                cnt++;
            end while (!etw.is_valid && cnt < 40);
            e = sb.pop_front();
            checks++;
            if ({etw.is_valid, etw.result, etw.pc} !== {1'b1, e.result, e.pc} || cnt !== 34)
                $display("FAIL div_%0d: valid=%b res=%h lat=%0d expected valid=1 res=%h lat=34",
                         i, etw.is_valid, etw.result, cnt, e.result);
            else passes++;
            @(negedge clock);
            idle(1'b0);
        end
    endtask
`endif

    task automatic test_flush();
        @(negedge clock);
        idle(1'b1);
        @(posedge clock);
        #1;
        checks++;
        if ({etw.is_valid, etw.has_flushed} !== 2'b01)
            $display("FAIL flush_set: valid/flushed=%b%b expected 01",
                     etw.is_valid, etw.has_flushed);
        else passes++;
        @(negedge clock);
        idle(1'b0);
        @(posedge clock);
        #1;
        checks++;
        if ({etw.is_valid, etw.has_flushed} !== 2'b00)
            $display("FAIL flush_clear: valid/flushed=%b%b expected 00",
                     etw.is_valid, etw.has_flushed);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_undefined();
        test_mul();
        test_done_hold();
        test_hold_busy();
        test_reset_mid_busy();
`ifdef DIVIDE_EN
        test_div();
`endif
        test_flush();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 The module SHALL have a `reset_n` input, 1 bit: asynchronous, active-low reset.
REQ-002 The module SHALL have a `clock` input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have an `ini` port of type `i_read_to_execute.execute_in`.
  - Inputs: `is_valid`, `pc`, `destination`, `destination_is_memory`, `left_value`, `right_value`, `operation`, `adjustment`, `adjustment_operation`, `has_flushed`.
  - Output: `hold`.
REQ-004 The module SHALL have an `outi` port of type `i_execute_to_write.execute_out`.
  - Outputs: `is_valid`, `pc`, `destination`, `destination_is_memory`, `result` (regval_t, 32 bit), `has_flushed`.
  - Input: `hold`.

Function
REQ-005 The module SHALL form the effective right operand (eff_right) combinationally from `adjustment_operation`:
  - NONE: `right_value`.
  - ADD: `right_value + adjustment`, mod 2^32.
  - SHL: `right_value << adjustment[4:0]`.
REQ-006 Single-cycle operations (ADD, SUB, AND, OR, XOR, SHL, SHR) SHALL combine `left_value` and eff_right.
  - SHL/SHR are logical and use eff_right[4:0].
  - ADD/SUB wrap at 32 bits.
REQ-007 A single-cycle op with `ini.is_valid=1` and `outi.hold=0` SHALL register the result and the pass-through fields into `outi` at the next edge, with `outi.is_valid=1` (latency 1).
REQ-008 The multi-cycle op MUL (unsigned, low 32 bits of the product) SHALL use an iterative shift-add engine.
  - States: IDLE, BUSY, DONE.
REQ-009 IDLE->BUSY SHALL occur on an edge where `ini.is_valid=1` and the op is multi-cycle.
  - At that edge: load both operands and clear the 5-bit counter.
REQ-010 BUSY SHALL perform one step per edge and go to DONE on the step taken with counter=31 (32 steps).
REQ-011 In DONE with `outi.hold=0`, the next edge SHALL:
  - register the result to `outi` with `outi.is_valid=1`;
  - return to IDLE.
  - The instruction appears 34 cycles after it is first presented.
REQ-012 In DONE with `outi.hold=1`, the engine SHALL stay in DONE holding its result.
REQ-013 `ini.hold` SHALL equal `reset_n && (outi.hold || (ini.is_valid && is_multicycle(ini.operation) && state!=DONE))`, combinationally.
REQ-014 While `outi.hold=1`, all `outi` registers SHALL keep their values; BUSY iteration continues.
REQ-015 When `ini.is_valid=0` and `outi.hold=0`, the module SHALL drive `outi.is_valid<=0` and `outi.has_flushed<=ini.has_flushed`.
REQ-016 `has_flushed`, `pc`, `destination` and `destination_is_memory` SHALL pass through unmodified alongside the result.
REQ-017 An undefined `operation` code SHALL produce `result=0` and a valid single-cycle output.

Reset
REQ-018 While `reset_n=0`, the module SHALL force:
  - `outi.is_valid=0`, `outi.has_flushed=0`;
  - state=IDLE, counter=0.
  - Other `outi` fields are don't-care.
REQ-019 Reset asserted mid-BUSY SHALL abandon the operation; after reset the engine restarts from IDLE.
REQ-020 `ini.hold` SHALL be 0 while in reset.

Configuration
REQ-021 When `DIVIDE_EN` is defined, the module SHALL add multi-cycle ops DIVU and REMU.
  - 32-step restoring divider sharing the BUSY/DONE state machine and counter; same 34-cycle latency.
  - Divide by zero: quotient=32'hFFFF_FFFF, remainder=`left_value`.
REQ-022 When `DIVIDE_EN` is undefined, DIVU/REMU SHALL be treated as undefined operations per REQ-017 and no divider logic SHALL be synthesised.

Structure
REQ-023 The shared core package SHALL hold:
  - `regval_t`;
  - the `operation_t` enum, including DIVU/REMU codes, which are always reserved;
  - the `adjustment_operation_t` enum;
  - function `is_multicycle()`, whose DIVU/REMU result is gated by `DIVIDE_EN`.
REQ-024 The iterative engine SHALL be the sub-module `iterative_muldiv`.
  - Inputs: start, op, a, b.
  - Outputs: busy, done, result.
  - It is held in DONE by an ack input.

Verification
REQ-025 ADD with left=5, right=7, adjustment_operation=ADD, adjustment=3 -> `outi.result=15`, `outi.is_valid=1` one edge later.
REQ-026 MUL with 0xFFFF_FFFF x 2 -> `ini.hold=1` for 33 cycles, result 0xFFFF_FFFE valid on the 34th edge, then `ini.hold=0`.
REQ-027 `outi.hold` raised during DONE for 5 cycles -> DONE persists, `outi` unchanged; result delivered on the first edge after release.
REQ-028 `reset_n` pulsed low at BUSY counter=10 -> `outi.is_valid=0`, `ini.hold=0`; a subsequent ADD completes normally in 1 cycle.
REQ-029 With `DIVIDE_EN`: DIVU 100/7 -> 14, REMU 100/7 -> 2, DIVU 9/0 -> 0xFFFF_FFFF. Without `DIVIDE_EN`: DIVU -> result 0 in 1 cycle.
REQ-030 Invalid input with `has_flushed=1` -> `outi.is_valid=0`, `outi.has_flushed=1` next edge.
